// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes and FSM encodings shared by the ALU execute unit
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b0101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_comb_core.sv
// rtl/alu_comb_core.sv - combinational AND/OR/ADD/SUB datapath with legality decode
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_legal
);

  // single-cycle ops; anything else reports not-legal with a zero result
  always_comb begin
    o_result = '0;
    o_legal  = 1'b1;
    case (i_op)
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_ADD:  o_result = i_a + i_b;
      OP_SUB:  o_result = i_a - i_b;
      default: o_legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage ALU with valid/ready handshake; iterative SLL/SRL under ALU_SHIFT_EN
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  logic [WIDTH-1:0] w_core_result;
  logic             w_core_legal;
  logic             w_accept;
  logic             w_out_free;
  logic             w_load;
  logic [WIDTH-1:0] w_load_result;
  logic             w_load_illegal;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_illegal;

  alu_comb_core #(.WIDTH(WIDTH)) u_core (
    .i_op     (op),
    .i_a      (a),
    .i_b      (b),
    .o_result (w_core_result),
    .o_legal  (w_core_legal)
  );

  assign w_accept   = in_valid & in_ready;
  assign w_out_free = ~r_out_valid | out_ready;

`ifdef ALU_SHIFT_EN
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_sh;
  logic [SHW-1:0]   r_cnt;
  logic             r_left;
  logic [SHW-1:0]   w_shamt;
  logic             w_is_shift;
  logic             w_start_shift;
  logic             w_last;
  logic [WIDTH-1:0] w_sh_step;

  assign w_shamt       = b[SHW-1:0];
  assign w_is_shift    = (op == OP_SLL) | (op == OP_SRL);
  assign w_start_shift = w_accept & w_is_shift & (w_shamt != '0);
  assign w_last        = (r_cnt == CNT_ONE);
  assign w_sh_step     = r_left ? (r_sh << 1) : (r_sh >> 1);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // next state: the last shift step goes straight to the output when it is free
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_start_shift) w_next_state = S_SHIFT;
      S_SHIFT: if (w_last) w_next_state = w_out_free ? S_IDLE : S_WAIT;
      S_WAIT:  if (w_out_free) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM outputs: accept only in IDLE, select what loads into the output register
  always_comb begin
    in_ready       = (r_state == S_IDLE) & w_out_free;
    w_load         = 1'b0;
    w_load_result  = w_core_result;
    w_load_illegal = ~w_core_legal;
    case (r_state)
      S_IDLE: begin
        w_load = w_accept & ~w_start_shift;
        if (w_is_shift) begin
          w_load_result  = a;
          w_load_illegal = 1'b0;
        end
      end
      S_SHIFT: begin
        w_load         = w_last & w_out_free;
        w_load_result  = w_sh_step;
        w_load_illegal = 1'b0;
      end
      S_WAIT: begin
        w_load         = w_out_free;
        w_load_result  = r_sh;
        w_load_illegal = 1'b0;
      end
      default: w_load = 1'b0;
    endcase
  end

  // shift register and remaining-step counter; one bit per cycle while shifting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh   <= '0;
      r_cnt  <= '0;
      r_left <= 1'b0;
    end else if (w_start_shift) begin
      r_sh   <= a;
      r_cnt  <= w_shamt;
      r_left <= (op == OP_SLL);
    end else if (r_state == S_SHIFT) begin
      r_sh  <= w_sh_step;
      r_cnt <= r_cnt - CNT_ONE;
    end
  end
`else
  // without shifts every accepted op completes in one cycle
  always_comb begin
    in_ready       = w_out_free;
    w_load         = w_accept;
    w_load_result  = w_core_result;
    w_load_illegal = ~w_core_legal;
  end
`endif

  // single-entry output register: holds until the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_result    <= w_load_result;
      r_zero      <= ~|w_load_result;
      r_illegal   <= w_load_illegal;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign illegal   = r_illegal;

endmodule
